// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the memory macro.
//   master : requester/memory side (drives req/we/lock/addr/wdata and mem_rdata)
//   slave  : arbiter side (drives gnt/rvalid/rdata and the mem_* strobes/address/data)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port system memory.
//   m0 = RV32 core, m1 = loader/debug DMA. One access granted per cycle,
//   zero-cycle grant, read data returned one cycle after the grant to the
//   issuing port, locked sequences for atomic read-modify-write.
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset (also masks gnt/rvalid while low)
//   bus      mem_port_arbiter_if.slave: m0_*/m1_* requester ports, mem_* macro port
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin on conflict (winner != last_gnt)
//   MEM_ARB_RR_EN undefined -> fixed priority, m0 wins on conflict
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_st_e;

  lock_st_e          lock_st, lock_st_nx;
  logic              lock_owner, lock_owner_nx;
  logic              last_gnt, last_gnt_nx;
  logic              rd_pend, rd_pend_nx;
  logic              rd_owner, rd_owner_nx;

  logic              elig0, elig1, win1, gnt_any;
  logic              win_we, win_lock;
  logic              rv0, rv1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_st    <= UNLOCKED;
      lock_owner <= 1'b0;
      last_gnt   <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      lock_st    <= lock_st_nx;
      lock_owner <= lock_owner_nx;
      last_gnt   <= last_gnt_nx;
      rd_pend    <= rd_pend_nx;
      rd_owner   <= rd_owner_nx;
    end
  end

  // Arbitration, memory steering, lock tracking and read return
  always_comb begin
    lock_st_nx       = lock_st;
    lock_owner_nx    = lock_owner;
    last_gnt_nx      = last_gnt;
    rd_pend_nx       = 1'b0;
    rd_owner_nx      = rd_owner;
    bus.m0_gnt       = 1'b0;
    bus.m1_gnt       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_r_enable = 1'b0;
    bus.mem_w_enable = 1'b0;

    // While locked only the owner is eligible; the other port simply stalls.
    elig0 = bus.m0_req && (lock_st == UNLOCKED || !lock_owner);
    elig1 = bus.m1_req && (lock_st == UNLOCKED ||  lock_owner);

    if (elig0 && elig1) begin
`ifdef MEM_ARB_RR_EN
      win1 = !last_gnt;
`else
      win1 = 1'b0;
`endif
    end else begin
      win1 = elig1;
    end

    gnt_any   = reset_n && (elig0 || elig1);
    win_we    = win1 ? bus.m1_we    : bus.m0_we;
    win_lock  = win1 ? bus.m1_lock  : bus.m0_lock;
    win_addr  = win1 ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win1 ? bus.m1_wdata : bus.m0_wdata;

    if (gnt_any) begin
      bus.m0_gnt       = !win1;
      bus.m1_gnt       = win1;
      bus.mem_addr     = win_addr;
      bus.mem_wdata    = win_wdata;
      bus.mem_r_enable = !win_we;
      bus.mem_w_enable = win_we;
      last_gnt_nx      = win1;
      rd_pend_nx       = !win_we;
      rd_owner_nx      = win1;
      // A grant can only go to the owner while locked, so lock=0 here releases.
      if (win_lock) begin
        lock_st_nx    = LOCKED;
        lock_owner_nx = win1;
      end else begin
        lock_st_nx    = UNLOCKED;
      end
    end

    // Pending read data is dropped while reset is asserted.
    rv0 = reset_n && rd_pend && !rd_owner;
    rv1 = reset_n && rd_pend &&  rd_owner;
    bus.m0_rvalid = rv0;
    bus.m1_rvalid = rv1;
    bus.m0_rdata  = rv0 ? bus.mem_rdata : '0;
    bus.m1_rdata  = rv1 ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single-port system memory between the multi-cycle RV32 core (port m0) and a secondary master such as the program loader/debug DMA (port m1). It grants one access per cycle, returns read data with fixed one-cycle latency to the requester that issued the read, and supports locked sequences for atomic read-modify-write. It sits between the masters and the memory macro, which sees one `mem_addr`/`mem_r_enable`/`mem_w_enable`/`mem_wdata`/`mem_rdata` port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- m0_req, m1_req  in  1  access request; level, held until gnt
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_lock, m1_lock  in  1  keep ownership after this access
- m0_addr, m1_addr  in  ADDR_W  access address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  access accepted this cycle
- m0_rvalid, m1_rvalid  out  1  read data valid
- m0_rdata, m1_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  memory address
- mem_r_enable, mem_w_enable  out  1  memory strobes
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_r_enable

## Operation
- Registered state: `lock_st` (UNLOCKED / LOCKED), `lock_owner` (0/1), `last_gnt` (0/1), `rd_pend` (1), `rd_owner` (0/1).
- Arbitration, UNLOCKED: single requester wins; on conflict the winner comes from the policy under Configuration.
- Arbitration, LOCKED: only `lock_owner` can be granted. The other requester stalls, with gnt=0 and its request held.
- At most one gnt per cycle. Winner's addr/wdata drive mem_*. mem_r_enable = gnt & !we; mem_w_enable = gnt & we.
- No grant: mem strobes 0, mem_addr 0, mem_wdata 0.
- Write completes in the grant cycle.
- Read granted in cycle N: rd_pend=1 and rd_owner=winner at N+1. At N+1, mX_rvalid=1 for rd_owner only, and mX_rdata = mem_rdata.
- mX_rdata is 0 when that port's rvalid is 0.
- Lock: a grant with lock=1 enters or stays in LOCKED with lock_owner=winner. A grant to the owner with lock=0 returns to UNLOCKED after that access.
- Owner dropping req while LOCKED keeps the lock; there is no timeout.
- Requester rules: req, we, lock, addr and wdata stay stable from req rise until gnt. req may stay high for back-to-back accesses, one per cycle.
- `last_gnt` updates to the winner on every grant.

## Timing
- gnt and mem_* are combinational from req/state, with zero-cycle grant latency.
- Read latency: gnt cycle N, rvalid cycle N+1, exactly one cycle wide.
- Throughput: one access per cycle. A new grant is allowed in the same cycle as an rvalid, including back-to-back reads by different requesters.
- Reset (reset_n=0 at posedge):
  - all gnt, rvalid and mem strobes are 0; rdata, mem_addr and mem_wdata are 0
  - lock_st=UNLOCKED, rd_pend=0, last_gnt=1, so m0 is favoured first
- Reset during a pending read drops the rvalid.
- Simultaneous lock release by the owner and a request from the other port: the release access is granted this cycle, and the other port can win from the next cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict. The requester not equal to last_gnt wins, so alternating grants are guaranteed under continuous contention.
- MEM_ARB_RR_EN undefined: fixed priority, m0 (core) always wins on conflict. last_gnt is still maintained but not used.

## Test plan
- Reset: hold reset_n=0 with both req=1 -> all gnt, rvalid and strobes 0. After release, m0 alone reads addr 0x10 (mem holds 0xDEADBEEF) -> m0_gnt in cycle 1, m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 2, m1_rvalid=0.
- Conflict: both req continuously, reads to 0x100 (m0) and 0x200 (m1).
  - RR_EN: grants m0, m1, m0, m1.
  - Without RR_EN: m0 every cycle, m1_gnt=0.
- Back-to-back: m1 read 0x4 granted at N, m0 read 0x8 granted at N+1 -> m1_rvalid at N+1, m0_rvalid at N+2, each with the correct data.
- Write: m1 write 0x20 with data 0x12345678 -> mem_w_enable=1, mem_addr=0x20, mem_wdata=0x12345678 in the gnt cycle. A following m0 read of 0x20 returns 0x12345678.
- Lock: m1 read 0x30 with lock=1, then write 0x30 with lock=0, while m0 requests throughout -> m0_gnt=0 during both m1 accesses, m0 granted the cycle after the unlocking write.
- Reset mid-read: assert reset_n=0 in the cycle after a read gnt -> no rvalid on either port afterwards; state is UNLOCKED.
